// File: rtl/prim_arbiter_wrr_pkt.sv
// -----------------------------------------------------------------------------
// prim_arbiter_wrr_pkt
//
// N:1 weighted round-robin arbiter that grants at packet granularity. Once a
// requester wins, it keeps the output for a window of whole packets (its
// weight, 0 treated as 1), so beats of different packets never interleave.
// The arbitration decision is also held while the sink stalls.
//
// Ports
//   clk_i     in   clock
//   rst_ni    in   asynchronous active-low reset
//   req_i     in   [N]         per-requester valid, held until granted
//   data_i    in   [N][DW]     per-requester beat data
//   last_i    in   [N]         per-requester end-of-packet marker
//   weight_i  in   [N][WeightW] packets per grant window (0 acts as 1)
//   gnt_o     out  [N]         one-hot beat accept (selected req & ready_i)
//   idx_o     out  [IdxW]      index of the selected requester
//   valid_o   out              beat valid to sink
//   data_o    out  [DW]        data of the selected requester
//   last_o    out              end-of-packet of the selected beat
//   ready_i   in               sink ready
// -----------------------------------------------------------------------------
module prim_arbiter_wrr_pkt #(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int WeightW = 4,
    parameter int IdxW    = $clog2(N)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N-1:0]                    req_i,
    input  logic [N-1:0][DW-1:0]            data_i,
    input  logic [N-1:0]                    last_i,
    input  logic [N-1:0][WeightW-1:0]       weight_i,
    output logic [N-1:0]                    gnt_o,
    output logic [IdxW-1:0]                 idx_o,
    output logic                            valid_o,
    output logic [DW-1:0]                   data_o,
    output logic                            last_o,
    input  logic                            ready_i
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [WeightW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [WeightW-1:0]   win_q, win_d;
    logic                 in_pkt_q, in_pkt_d;

    logic [IdxW-1:0]      winner;
    logic [WeightW-1:0]   wgt_eff;
    logic [IdxW-1:0]      sel;
    logic                 valid;
    logic                 xfer;
    logic                 sel_last;
    logic [WeightW:0]     cnt_inc;

    // Index increment that wraps at N, which need not be a power of two.
    function automatic logic [IdxW-1:0] inc_wrap(input logic [IdxW-1:0] v);
        return (v == IdxW'(N - 1)) ? '0 : v + 1'b1;
    endfunction

    // Round-robin search starting at ptr_q; winner stays 0 when nobody requests.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        logic found;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = int'(ptr_q) + k;
            if (c >= N) c = c - N;
            if (!found && req_i[c]) begin
                found  = 1'b1;
                winner = IdxW'(c);
            end
        end
    end

    assign wgt_eff = (weight_i[winner] == '0) ? WeightW'(1) : weight_i[winner];

    // Datapath select: the locked owner in LOCK, the fresh winner in ARB.
    always_comb begin
        sel   = winner;
        valid = |req_i;
        if (state_q == LOCK) begin
            sel   = owner_q;
            valid = req_i[owner_q];
        end
        xfer     = valid & ready_i;
        sel_last = last_i[sel];
        gnt_o    = '0;
        if (xfer) gnt_o[sel] = 1'b1;
    end

    assign idx_o   = sel;
    assign valid_o = valid;
    assign data_o  = data_i[sel];
    assign last_o  = sel_last & valid;

    // Compared one bit wider so a full window of 2^WeightW-1 packets cannot wrap.
    assign cnt_inc = {1'b0, pkt_cnt_q} + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        pkt_cnt_d = pkt_cnt_q;
        win_d     = win_q;
        in_pkt_d  = in_pkt_q;

        unique case (state_q)
            ARB: begin
                if (valid) begin
                    if (xfer && sel_last && (wgt_eff == WeightW'(1))) begin
                        // Single-packet window finished in one beat: no need to lock.
                        ptr_d = inc_wrap(winner);
                    end else begin
                        // Lock either to continue the packet/window or to hold
                        // the decision while the sink stalls.
                        state_d = LOCK;
                        owner_d = winner;
                        win_d   = wgt_eff;
                        if (xfer) begin
                            pkt_cnt_d = sel_last ? WeightW'(1) : '0;
                            in_pkt_d  = ~sel_last;
                        end else begin
                            pkt_cnt_d = '0;
                            in_pkt_d  = 1'b0;
                        end
                    end
                end
            end
            LOCK: begin
                if (xfer) begin
                    if (sel_last) begin
                        in_pkt_d = 1'b0;
                        if (cnt_inc >= {1'b0, win_q}) begin
                            state_d   = ARB;
                            ptr_d     = inc_wrap(owner_q);
                            pkt_cnt_d = '0;
                        end else begin
                            pkt_cnt_d = cnt_inc[WeightW-1:0];
                        end
                    end else begin
                        in_pkt_d = 1'b1;
                    end
                end else if (!in_pkt_q && !req_i[owner_q]) begin
                    // Owner went quiet between packets: give up the rest of the window.
                    state_d   = ARB;
                    ptr_d     = inc_wrap(owner_q);
                    pkt_cnt_d = '0;
                end
                // A mid-packet drop of req keeps the lock; the sink just sees a bubble.
            end
            default: state_d = ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            owner_q   <= '0;
            pkt_cnt_q <= '0;
            win_q     <= WeightW'(1);
            in_pkt_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            pkt_cnt_q <= pkt_cnt_d;
            win_q     <= win_d;
            in_pkt_q  <= in_pkt_d;
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));
    a_gnt_handshake : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|gnt_o) |-> (ready_i && valid_o));
    a_idx_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i) |=> $stable(idx_o));
    a_owner_in_pkt : assert property (@(posedge clk_i) disable iff (!rst_ni)
        in_pkt_q |=> $stable(owner_q));
`endif

endmodule

// File: tb/tb_prim_arbiter_wrr_pkt.sv
// -----------------------------------------------------------------------------
// tb_prim_arbiter_wrr_pkt
//
// Directed bench for prim_arbiter_wrr_pkt. Each requester is a small packet
// source (packet length, beats sent, packets left); expected grant order is
// written out by hand for each scenario.
// -----------------------------------------------------------------------------
module tb_prim_arbiter_wrr_pkt;

    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int WeightW = 4;
    localparam int IdxW    = 2;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic [N-1:0]              req_i;
    logic [N-1:0][DW-1:0]      data_i;
    logic [N-1:0]              last_i;
    logic [N-1:0][WeightW-1:0] weight_i;
    logic [N-1:0]              gnt_o;
    logic [IdxW-1:0]           idx_o;
    logic                      valid_o;
    logic [DW-1:0]             data_o;
    logic                      last_o;
    logic                      ready_i;

    prim_arbiter_wrr_pkt #(
        .N       (N),
        .DW      (DW),
        .WeightW (WeightW)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .data_i   (data_i),
        .last_i   (last_i),
        .weight_i (weight_i),
        .gnt_o    (gnt_o),
        .idx_o    (idx_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .last_o   (last_o),
        .ready_i  (ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    int pkt_len   [N];
    int beat      [N];
    int pkts_left [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] src_data(input int i);
        return {8'(i), 8'(pkts_left[i]), 16'(beat[i])};
    endfunction

    task automatic apply_srcs();
        for (int i = 0; i < N; i++) begin
            req_i[i]  = (pkts_left[i] > 0);
            last_i[i] = (beat[i] == pkt_len[i] - 1);
            data_i[i] = src_data(i);
        end
    endtask

    task automatic set_src(input int i, input int len, input int npkts);
        pkt_len[i]   = len;
        beat[i]      = 0;
        pkts_left[i] = npkts;
    endtask

    // Check the outputs mid-cycle, then let the sources react to the grant.
    task automatic step(input string tag, input int exp_idx, input bit exp_valid, input bit exp_last);
        logic [N-1:0] g;
        logic [N-1:0] exp_gnt;
        @(negedge clk_i);
        exp_gnt = '0;
        if (exp_valid && ready_i) exp_gnt[exp_idx] = 1'b1;
        check({tag, ".valid"}, 64'(valid_o), 64'(exp_valid));
        check({tag, ".idx"},   64'(idx_o),   64'(exp_idx));
        check({tag, ".gnt"},   64'(gnt_o),   64'(exp_gnt));
        check({tag, ".last"},  64'(last_o),  64'(exp_valid & exp_last));
        if (exp_valid) check({tag, ".data"}, 64'(data_o), 64'(src_data(exp_idx)));
        g = gnt_o;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                if (beat[i] == pkt_len[i] - 1) begin
                    beat[i] = 0;
                    pkts_left[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
        apply_srcs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_ni  = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            weight_i[i] = WeightW'(1);
            set_src(i, 1, 0);
        end
        apply_srcs();

        // Reset with no requests.
        #12;
        check("rst.gnt",   64'(gnt_o),   64'(0));
        check("rst.valid", 64'(valid_o), 64'(0));
        check("rst.last",  64'(last_o),  64'(0));
        check("rst.idx",   64'(idx_o),   64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        step("idle0", 0, 1'b0, 1'b0);

        // Weights 1, all request single-beat packets: plain rotation.
        set_src(0, 1, 2);
        set_src(1, 1, 1);
        set_src(2, 1, 1);
        set_src(3, 1, 1);
        apply_srcs();
        step("rr0", 0, 1'b1, 1'b1);
        step("rr1", 1, 1'b1, 1'b1);
        step("rr2", 2, 1'b1, 1'b1);
        step("rr3", 3, 1'b1, 1'b1);
        step("rr4", 0, 1'b1, 1'b1);
        step("idle1", 0, 1'b0, 1'b0);

        // Port1 weight 3 with 2-beat packets; ptr now 1 so port1 goes first.
        // Port0 weight 0 behaves as a one-packet window.
        weight_i[1] = WeightW'(3);
        weight_i[0] = WeightW'(0);
        set_src(1, 2, 3);
        set_src(0, 2, 1);
        apply_srcs();
        for (int b = 0; b < 6; b++) step($sformatf("wrr.p1b%0d", b), 1, 1'b1, (b % 2) == 1);
        step("wrr.p0b0", 0, 1'b1, 1'b0);
        step("wrr.p0b1", 0, 1'b1, 1'b1);
        step("idle2", 0, 1'b0, 1'b0);
        weight_i[0] = WeightW'(1);
        weight_i[1] = WeightW'(1);

        // Port0 4-beat packet; port2 arrives at beat 2 and must wait.
        set_src(0, 4, 1);
        apply_srcs();
        step("lock.b0", 0, 1'b1, 1'b0);
        set_src(2, 1, 1);
        apply_srcs();
        step("lock.b1", 0, 1'b1, 1'b0);
        step("lock.b2", 0, 1'b1, 1'b0);
        step("lock.b3", 0, 1'b1, 1'b1);
        step("lock.p2", 2, 1'b1, 1'b1);
        step("idle3", 0, 1'b0, 1'b0);

        // Sink stall with ports 1 and 2 requesting (ptr is 3, so port1 wins).
        ready_i = 1'b0;
        set_src(1, 1, 1);
        set_src(2, 1, 1);
        apply_srcs();
        for (int s = 0; s < 5; s++) step($sformatf("stall%0d", s), 1, 1'b1, 1'b1);
        ready_i = 1'b1;
        step("stall.go", 1, 1'b1, 1'b1);
        step("stall.p2", 2, 1'b1, 1'b1);
        step("idle4", 0, 1'b0, 1'b0);

        // Reset while port1 is mid-packet in LOCK.
        set_src(1, 3, 1);
        apply_srcs();
        step("mid.b0", 1, 1'b1, 1'b0);
        set_src(0, 1, 1);
        set_src(3, 1, 1);
        apply_srcs();
        step("mid.b1", 1, 1'b1, 1'b0);
        rst_ni = 1'b0;
        #2;
        check("mid.rst.idx",   64'(idx_o),   64'(0));
        check("mid.rst.valid", 64'(valid_o), 64'(1));
        set_src(1, 3, 1);
        apply_srcs();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step("post.p0", 0, 1'b1, 1'b1);
        step("post.p1", 1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
